// File: rtl/pmem_line_responder_pkg.sv
// pmem_line_responder_pkg: shared line type and responder FSM states
package pmem_line_responder_pkg;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        PMEM_IDLE,
        PMEM_WAIT,
        PMEM_BURST,
        PMEM_RESP
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_line_serdes.sv
// line_serdes: 128-bit line register with whole-line capture and word-indexed load/extract
module line_serdes
    import pmem_line_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        capture,
    input  lc3b_line    capture_line,
    input  logic        load,
    input  logic [2:0]  idx,
    input  logic [15:0] word_in,
    output lc3b_line    line_q,
    output lc3b_line    line_next,
    output logic [15:0] word_out
);

    assign word_out = line_q[{idx, 4'b0} +: 16];

    // next line value: word idx replaced by the incoming word while loading
    always_comb begin
        line_next = line_q;
        if (load) line_next[{idx, 4'b0} +: 16] = word_in;
    end

    // capture a whole line on accept, otherwise follow the word-wise update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) line_q <= '0;
        else line_q <= capture ? capture_line : line_next;
    end

endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: serves 128-bit line reads/write-backs from a 16-bit word store in 8 beats
module pmem_line_responder
    import pmem_line_responder_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  lc3b_line              pmem_wdata,
    output logic                  pmem_resp,
    output lc3b_line              pmem_rdata,
    output logic                  pmem_error
);

    localparam int WW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
    localparam int LW = ADDR_WIDTH - 4;

    pmem_state_t           state;
    logic [LW-1:0]         line_addr;
    logic                  is_read;
    logic [2:0]            beat;
    logic [WW-1:0]         wait_cnt;
    logic [15:0]           store [2**(ADDR_WIDTH-1)];
    logic [ADDR_WIDTH-2:0] word_addr;
    logic [15:0]           word_out;
    lc3b_line              line_q;
    lc3b_line              line_next;
    logic                  accept;
    logic                  unused_addr_bits;

    assign accept           = state == PMEM_IDLE && (pmem_read || pmem_write);
    assign word_addr        = {line_addr, beat};
    assign unused_addr_bits = ^pmem_address[3:0];

    line_serdes u_serdes (
        .clk          (clk),
        .reset_n      (reset_n),
        .capture      (accept),
        .capture_line (pmem_wdata),
        .load         (state == PMEM_BURST && is_read),
        .idx          (beat),
        .word_in      (store[word_addr]),
        .line_q       (line_q),
        .line_next    (line_next),
        .word_out     (word_out)
    );

    // write-back beats commit one word per cycle; the store itself is never reset
    always_ff @(posedge clk) begin
        if (state == PMEM_BURST && !is_read) store[word_addr] <= word_out;
    end

    // request FSM; rdata takes line_next so beat 7 lands in the same edge that enters RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PMEM_IDLE;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            pmem_error <= 1'b0;
            line_addr  <= '0;
            is_read    <= 1'b0;
            beat       <= '0;
            wait_cnt   <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                PMEM_IDLE: if (pmem_read || pmem_write) begin
                    line_addr <= pmem_address[ADDR_WIDTH-1:4];
                    is_read   <= pmem_read & ~pmem_write;
                    if (pmem_read & pmem_write) pmem_error <= 1'b1;
                    beat      <= '0;
                    wait_cnt  <= '0;
                    state     <= LATENCY > 0 ? PMEM_WAIT : PMEM_BURST;
                end
                PMEM_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WW'(LATENCY - 1)) state <= PMEM_BURST;
                end
                PMEM_BURST: begin
                    beat <= beat + 3'd1;
                    if (beat == 3'd7) begin
                        state     <= PMEM_RESP;
                        pmem_resp <= 1'b1;
                        if (is_read) pmem_rdata <= line_next;
                    end
                end
                PMEM_RESP: state <= PMEM_IDLE;
                default:   state <= PMEM_IDLE;
            endcase
        end
    end

endmodule
